// File: rtl/i2s_audio_tx_if.sv
// Frame handshake between the audio mixer and the I2S transmitter.
// The mixer drives the stereo pair and valid; the transmitter returns ready.
interface i2s_audio_tx_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
  modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_audio_tx.sv
// Serial audio transmitter: one-frame holding register, BCK divider and a frame
// shifter emitting I2S, left- or right-justified data; repeats the last frame on underrun.
module i2s_audio_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int BCK_DIV  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    mode,
  i2s_audio_tx_if.slave s_if,
  output logic          I2S_BCK,
  output logic          I2S_LRCK,
  output logic          I2S_DATA,
  output logic          frame_start,
  output logic          underrun
);
  localparam int IDX_W = $clog2(2 * SLOT_W);
  localparam int CNT_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BCK_DIV - 1);
  localparam int PAD = SLOT_W - SAMPLE_W;

  typedef enum logic [1:0] {FMT_I2S = 2'd0, FMT_LJ = 2'd1, FMT_RJ = 2'd2} fmt_e;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bck_q, bck_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                lrck_q, lrck_d;
  logic                data_q, data_d;
  logic                ready_q, ready_d;
  logic                fs_q, fs_d;
  logic                ur_q, ur_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic [SAMPLE_W-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  fmt_e                fmt_q, fmt_d;

  logic                tick, load, accept, right_ch;
  int                  idx_i, pos_i;
  logic [SAMPLE_W-1:0] word, shifted;

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    bck_d       = bck_q;
    idx_d       = idx_q;
    lrck_d      = lrck_q;
    data_d      = data_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    fmt_d       = fmt_q;
    tick        = 1'b0;
    load        = 1'b0;
    accept      = s_if.sample_valid & ready_q;
    right_ch    = 1'b0;
    idx_i       = 0;
    pos_i       = 0;
    word        = '0;
    shifted     = '0;

    // A bit tick is the falling BCK toggle; everything serial moves on it.
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      bck_d = ~bck_q;
      tick  = bck_q;
    end
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      load  = (idx_d == '0);
    end

    if (load) begin
      fs_d  = 1'b1;
      ur_d  = ~hold_full_q;
      fmt_d = (mode == 2'd3) ? FMT_I2S : fmt_e'(mode);
      if (hold_full_q) begin
        shift_l_d   = hold_l_q;
        shift_r_d   = hold_r_q;
        last_l_d    = hold_l_q;
        last_r_d    = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        shift_l_d = last_l_q;
        shift_r_d = last_r_q;
      end
    end

    // Acceptance is applied after the load so a same-cycle load sees the old holding state.
    if (accept) begin
      hold_l_d    = s_if.sample_l;
      hold_r_d    = s_if.sample_r;
      hold_full_d = 1'b1;
    end

    if (tick) begin
      idx_i    = int'(idx_d);
      right_ch = (idx_i >= SLOT_W);
      pos_i    = right_ch ? idx_i - SLOT_W : idx_i;
      word     = right_ch ? shift_r_d : shift_l_d;
      if (fmt_d == FMT_RJ && pos_i < PAD) begin
        data_d = word[SAMPLE_W-1];
      end else if (fmt_d == FMT_RJ) begin
        shifted = word >> (SLOT_W - 1 - pos_i);
        data_d  = shifted[0];
      end else if (pos_i < SAMPLE_W) begin
        shifted = word >> (SAMPLE_W - 1 - pos_i);
        data_d  = shifted[0];
      end else begin
        data_d = 1'b0;
      end
      // I2S word select switches one bit ahead of the slot it names.
      lrck_d = (fmt_d == FMT_I2S) ? (idx_i >= SLOT_W - 1 && idx_i <= 2 * SLOT_W - 2) : right_ch;
    end

    ready_d = ~hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      bck_q       <= 1'b0;
      idx_q       <= LAST_IDX;
      lrck_q      <= 1'b0;
      data_q      <= 1'b0;
      ready_q     <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      last_l_q    <= '0;
      last_r_q    <= '0;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
      fmt_q       <= FMT_I2S;
    end else begin
      cnt_q       <= cnt_d;
      bck_q       <= bck_d;
      idx_q       <= idx_d;
      lrck_q      <= lrck_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      fmt_q       <= fmt_d;
    end
  end

  assign s_if.sample_ready = ready_q;
  assign I2S_BCK           = bck_q;
  assign I2S_LRCK          = lrck_q;
  assign I2S_DATA          = data_q;
  assign frame_start       = fs_q;
  assign underrun          = ur_q;
endmodule
